// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the hh:mm:ss mode/time-set controller:
// mode encodings, BCD field limits, time_bcd field offsets and BCD helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_t;

  // Limits held in BCD so they compare directly against the digit pairs.
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // LSB of each two-digit field inside time_bcd.
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 8;
  localparam int HR_LSB  = 16;

  // Any digit outside its legal range reads as 0.
  function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] lim);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > lim[7:4]) ? 4'd0 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd0 : v[3:0];
    return {t, u};
  endfunction

  function automatic logic bcd_at_max(input logic [7:0] v, input logic [7:0] lim);
    return bcd_clean(v, lim) >= lim;
  endfunction

  // Wrapping increment; a value at or past the limit wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] c;
    c = bcd_clean(v, lim);
    if (c >= lim) return 8'h00;
    if (c[3:0] == 4'd9) return {c[7:4] + 4'd1, 4'd0};
    return {c[7:4], c[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the clock controller, the 1 Hz divider, the buttons
// and the seven-segment scan logic. master = stimulus/consumer side,
// slave = controller side.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic        tick_1hz;
  logic        btn_mode;
  logic        btn_inc;
  logic [23:0] time_bcd;
  mode_t       mode;
  logic [3:0]  blink_mask;
  logic        day_pulse;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  time_bcd, mode, blink_mask, day_pulse
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output time_bcd, mode, blink_mask, day_pulse
  );

endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability down-counter and a
// one-cycle press pulse on the debounced rising edge. A new level is accepted
// after DB_CYCLES consecutive samples that differ from the current level.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count down while the input disagrees with the accepted level; accept at terminal count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= CNT_LOAD;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        press <= sync2;
        cnt   <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and time-set controller for the hh:mm:ss BCD clock.
// Owns the time register, advances it on tick_1hz in RUN, lets the user edit
// hours then minutes with two buttons, and drives per-digit blink masks.
// Optional build macro: CLOCK_AUTO_REPEAT_EN (auto-repeat of held inc button).
//
// state        | meaning
// MODE_RUN     | time advances on tick_1hz, inc ignored
// MODE_SET_HR  | time frozen, inc bumps hours (23 -> 00), hour digits blink
// MODE_SET_MIN | time frozen, inc bumps minutes (59 -> 00), minute digits blink;
//              | leaving clears seconds
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic            clk,
  input  logic            clr,
  clock_set_ctrl_if.slave bus
);

  mode_t       state;
  logic [7:0]  hr_q;
  logic [7:0]  min_q;
  logic [7:0]  sec_q;
  logic        blink_phase;
  logic        phase_nx;
  logic [3:0]  mask_q;
  logic        day_q;
  logic        mode_press;
  logic        mode_level;
  logic        inc_press;
  logic        inc_level;
  logic        inc_evt;
  logic        unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .clr   (clr),
    .raw   (bus.btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .clr   (clr),
    .raw   (bus.btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  assign unused_levels = mode_level ^ inc_level;

`ifdef CLOCK_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;

  // Down-counter armed by a press in a SET mode; fires at terminal count, then reloads the rate.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rpt_cnt  <= '0;
      rpt_fire <= 1'b0;
    end else begin
      rpt_fire <= 1'b0;
      if (state == MODE_RUN || mode_press || !inc_level) begin
        rpt_cnt <= '0;
      end else if (inc_press) begin
        rpt_cnt <= RW'(REPEAT_DELAY - 1);
      end else if (rpt_cnt == RW'(1)) begin
        rpt_cnt  <= RW'(REPEAT_RATE);
        rpt_fire <= 1'b1;
      end else if (rpt_cnt != '0) begin
        rpt_cnt <= rpt_cnt - 1'b1;
      end
    end
  end

  assign inc_evt = inc_press | rpt_fire;
`else
  localparam int unused_repeat = REPEAT_DELAY + REPEAT_RATE;

  assign inc_evt = inc_press;
`endif

  // An edit forces the field visible; otherwise the phase flips once a second.
  assign phase_nx = inc_evt ? 1'b0 : (bus.tick_1hz ? ~blink_phase : blink_phase);

  // Mode sequencing, time register update and registered display controls.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= MODE_RUN;
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      blink_phase <= 1'b0;
      mask_q      <= 4'b0000;
      day_q       <= 1'b0;
    end else begin
      blink_phase <= phase_nx;
      day_q       <= 1'b0;
      case (state)
        MODE_RUN: begin
          if (bus.tick_1hz) begin
            sec_q <= bcd_inc(sec_q, SEC_MAX);
            if (bcd_at_max(sec_q, SEC_MAX)) begin
              min_q <= bcd_inc(min_q, MIN_MAX);
              if (bcd_at_max(min_q, MIN_MAX)) begin
                hr_q  <= bcd_inc(hr_q, HR_MAX);
                day_q <= bcd_at_max(hr_q, HR_MAX);
              end
            end
          end
          if (mode_press) begin
            state  <= MODE_SET_HR;
            mask_q <= {phase_nx, phase_nx, 2'b00};
          end else begin
            mask_q <= 4'b0000;
          end
        end
        MODE_SET_HR: begin
          if (inc_evt) hr_q <= bcd_inc(hr_q, HR_MAX);
          if (mode_press) begin
            state  <= MODE_SET_MIN;
            mask_q <= {2'b00, phase_nx, phase_nx};
          end else begin
            mask_q <= {phase_nx, phase_nx, 2'b00};
          end
        end
        MODE_SET_MIN: begin
          if (inc_evt) min_q <= bcd_inc(min_q, MIN_MAX);
          if (mode_press) begin
            state  <= MODE_RUN;
            sec_q  <= 8'h00;
            mask_q <= 4'b0000;
          end else begin
            mask_q <= {2'b00, phase_nx, phase_nx};
          end
        end
        default: begin
          state  <= MODE_RUN;
          mask_q <= 4'b0000;
        end
      endcase
    end
  end

  assign bus.time_bcd[HR_LSB  +: 8] = hr_q;
  assign bus.time_bcd[MIN_LSB +: 8] = min_q;
  assign bus.time_bcd[SEC_LSB +: 8] = sec_q;
  assign bus.mode                   = state;
  assign bus.blink_mask             = mask_q;
  assign bus.day_pulse              = day_q;

endmodule
